pe_acc_drain: RTL
=================

// Module: pe_acc_drain
// PURPOSE
//  Downstream of the PE: drains one accum_buf bank over abuf_rd_* after switch_a.
//  Each RES_W lane is requantised to DATA_W: round, shift, saturate, optional ReLU.
//  Converted vectors stream out over valid/ready to the output writer / DDR packer.
//  Credit-based read issue: no read result is ever dropped under backpressure.
// PARAMETERS
//  BATCH      4    lanes per accumulator word
//  DATA_W     16   output lane width (signed)
//  RES_W      32   accumulator lane width (signed)
//  BUF_DEPTH  256  accum_buf depth; ADDR_W = bw(BUF_DEPTH)
//  RD_LAT     2    cycles from abuf_rd_en to abuf_rd_data valid (fixed)
//  FIFO_DEPTH 8    output FIFO entries; must be >= RD_LAT+3 for full rate
// PORTS
//  clk          in  1               clock
//  rst          in  1               async reset, ACTIVE-LOW
//  start        in  1               1-cycle pulse; accepted only in IDLE
//  rd_base      in  ADDR_W          first accum_buf address
//  rd_len       in  ADDR_W+1        words to drain, 0..BUF_DEPTH
//  shift        in  5               right-shift amount, 0..RES_W-1
//  relu_en      in  1               clamp negative results to 0
//  busy         out 1               high from accepted start until done
//  done         out 1               1-cycle pulse, job complete
//  abuf_rd_addr out ADDR_W          read address to PE accum_buf
//  abuf_rd_en   out 1               read strobe to PE accum_buf
//  abuf_rd_data in  BATCH*RES_W     read data, valid RD_LAT cycles after rd_en
//  out_data     out BATCH*DATA_W    converted vector, lane i at [i*DATA_W +: DATA_W]
//  out_valid    out 1               out_data valid
//  out_ready    in  1               consumer accepts when valid&&ready
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE; counters, FIFO, delay line cleared.
//   busy/done/abuf_rd_en/out_valid=0; abuf_rd_addr=0; out_data=0.
//  FSM IDLE->RUN: start latches rd_base/rd_len/shift/relu_en.
//   start with rd_len=0: no reads; done pulses next cycle; stay IDLE.
//   start outside IDLE is ignored; config inputs sampled only on accepted start.
//  RUN: issue abuf_rd_en when issued<rd_len && (fifo_cnt+inflight)<FIFO_DEPTH.
//   inflight = reads issued, not yet written into FIFO (RD_LAT+1 stages).
//  RUN->DRAIN on last issue; DRAIN->IDLE when the last word is handshaked.
//   done pulses the cycle after that handshake; busy drops with done.
//  Address: rd_base+k mod BUF_DEPTH; wraps 255->0 for BUF_DEPTH=256.
//  Valid-tracking delay line RD_LAT deep; capture abuf_rd_data at its tap.
//   Convert combinationally, register into FIFO the next cycle.
//  Conversion per lane, signed, RES_W+1 bit intermediate (no overflow):
//   r = (shift==0) ? x : (x + (1<<(shift-1))) >>> shift   (round half up)
//   saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; if relu_en && r<0 -> 0.
//  FIFO: first-word-fall-through behind a registered output.
//   out_data/out_valid held stable while out_valid && !out_ready.
//   FIFO write and read in the same cycle is legal, incl. full/empty edges.
//   Credit rule guarantees no overflow; output order = address order.
//  Latency (RD_LAT=2, out_ready=1): start@0 -> first rd_en@1 -> first out_valid@5.
//   Afterwards 1 word/cycle.
//  Reset mid-job: drops in-flight reads and FIFO contents.
//   No done pulse; next start behaves as after power-up.
// TESTING
//  1 base=0,len=4,shift=0, lanes=small ints, ready=1.
//    -> rd_en @1..4, out_valid @5..8 with same values, done @9.
//  2 shift=16: x=0x00018000->2; shift=4: x=0x7FFFFFFF->0x7FFF;
//    shift=1: x=-3->-1, x=-4->-2; relu_en=1: x=-4->0.
//  3 len=16, out_ready=0 for 20 cycles -> rd_en stops after 8 reads.
//    Release ready -> all 16 words, in order, none lost/duplicated.
//  4 base=250,len=10 -> abuf_rd_addr 250..255,0..3, done once.
//  5 len=0 -> done @1, no rd_en, no out_valid; start while busy is ignored.
//  6 assert rst low mid-job (word 5 of 16) -> outputs 0 immediately.
//    Fresh job then completes correctly.

Source files
------------

// File: rtl/pe_acc_drain.sv
// Drains one accum_buf bank, requantises each accumulator lane to DATA_W
// and streams the vectors out over valid/ready under read-credit flow control.
module pe_acc_drain #(
  parameter int BATCH      = 4,
  parameter int DATA_W     = 16,
  parameter int RES_W      = 32,
  parameter int BUF_DEPTH  = 256,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = $clog2(BUF_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         rd_base,
  input  logic [ADDR_W:0]           rd_len,
  input  logic [4:0]                shift,
  input  logic                      relu_en,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         abuf_rd_addr,
  output logic                      abuf_rd_en,
  input  logic [BATCH*RES_W-1:0]    abuf_rd_data,
  output logic [BATCH*DATA_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OUT_W = BATCH * DATA_W;
  localparam logic signed [RES_W:0] SAT_MAX = {{(RES_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [RES_W:0] SAT_MIN = {{(RES_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_issued;
  logic [ADDR_W:0]     r_popped;
  logic [4:0]          r_shift;
  logic                r_relu;
  logic [CNT_W-1:0]    r_used;
  logic [RD_LAT-1:0]   r_vld;
  logic [OUT_W-1:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_cnt;
  logic [OUT_W-1:0]    r_out_data;
  logic                r_out_valid;

  logic                w_can_issue;
  logic                w_issue;
  logic                w_pop;
  logic                w_fifo_wr;
  logic                w_fifo_rd;
  logic [ADDR_W-1:0]   w_next_addr;
  logic [OUT_W-1:0]    w_conv;

  // Round half up, arithmetic shift, saturate to DATA_W, optional ReLU.
  function automatic logic [DATA_W-1:0] conv_lane(input logic [RES_W-1:0] x,
                                                  input logic [4:0] sh,
                                                  input logic relu);
    logic signed [RES_W:0] xe;
    logic signed [RES_W:0] half;
    logic signed [RES_W:0] r;
    logic [DATA_W-1:0]     res;
    xe   = $signed({x[RES_W-1], x});
    half = $signed({{RES_W{1'b0}}, 1'b1} << (sh - 5'd1));
    if (sh == 5'd0) begin
      r = xe;
    end else begin
      r = (xe + half) >>> sh;
    end
    if (relu && r[RES_W]) begin
      res = '0;
    end else if (r > SAT_MAX) begin
      res = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (r < SAT_MIN) begin
      res = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      res = r[DATA_W-1:0];
    end
    return res;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  always_comb begin
    w_conv = '0;
    for (int i = 0; i < BATCH; i++) begin
      w_conv[i*DATA_W +: DATA_W] = conv_lane(abuf_rd_data[i*RES_W +: RES_W], r_shift, r_relu);
    end
  end

  // A credit is held from issue until the word leaves through out_valid/out_ready.
  assign w_can_issue = (r_issued < r_len) && (r_used < CNT_W'(FIFO_DEPTH));
  assign w_issue     = ((r_state == S_IDLE) && start && (rd_len != '0)) ||
                       ((r_state == S_RUN) && w_can_issue);
  assign w_pop       = r_out_valid && out_ready;
  assign w_fifo_wr   = r_vld[RD_LAT-1];
  assign w_fifo_rd   = (r_cnt != '0) && (!r_out_valid || out_ready);
  assign w_next_addr = (r_addr == ADDR_W'(BUF_DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rd_en  <= 1'b0;
      r_addr   <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_popped <= '0;
      r_shift  <= 5'd0;
      r_relu   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      if (w_pop) begin
        r_popped <= r_popped + (ADDR_W+1)'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len    <= rd_len;
            r_shift  <= shift;
            r_relu   <= relu_en;
            r_popped <= '0;
            if (rd_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy   <= 1'b1;
              r_rd_en  <= 1'b1;
              r_addr   <= rd_base;
              r_issued <= (ADDR_W+1)'(1);
              r_state  <= (rd_len == (ADDR_W+1)'(1)) ? S_DRAIN : S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_can_issue) begin
            r_rd_en  <= 1'b1;
            r_addr   <= w_next_addr;
            r_issued <= r_issued + (ADDR_W+1)'(1);
            if ((r_issued + (ADDR_W+1)'(1)) == r_len) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && (r_popped == (r_len - (ADDR_W+1)'(1)))) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_used <= '0;
    end else begin
      case ({w_issue, w_pop})
        2'b10:   r_used <= r_used + CNT_W'(1);
        2'b01:   r_used <= r_used - CNT_W'(1);
        default: r_used <= r_used;
      endcase
    end
  end

  // Valid tracker aligned with the fixed read latency of accum_buf.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= r_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_fifo_wr) begin
        r_mem[r_wptr] <= w_conv;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_fifo_rd) begin
        r_rptr      <= ptr_inc(r_rptr);
        r_out_data  <= r_mem[r_rptr];
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
      case ({w_fifo_wr, w_fifo_rd})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign abuf_rd_en   = r_rd_en;
  assign abuf_rd_addr = r_addr;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;

endmodule
